mem_port_arbiter: RTL

Shares one single-port unified memory between the pipeline's instruction-fetch port and its load/store port. Sits between the RISC_V_pipeline_top fetch/memory stages and the memory model. It serialises accesses, stalls whichever stage is waiting, bounds fetch starvation with a streak limit, and aborts hung accesses with a watchdog. Data accesses win ties by default because they belong to the older instruction.

---
 rtl/riscv_mem_pkg.sv | 13 +
 rtl/arb_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared memory-side types and default widths for the pipeline and its arbiter
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts busy cycles and flags the cycle an access has run out of time
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // busy-cycle counter, cleared at the edge an access finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign expire = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store accesses onto one single-port memory
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    arb_state_t    state, state_nx;
    logic [SW-1:0] streak;
    logic          streak_max;
    logic          busy;
    logic          expire;
    logic          done;
    logic          grant_d;
    logic          grant_i;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (done),
        .en    (busy),
        .expire(expire)
    );

    assign streak_max = streak == SW'(MAX_D_STREAK);

    // grant decision and next state; data wins ties until the fetch streak limit is hit
    always_comb begin
        busy     = state != IDLE;
        done     = busy && (mem_ack || expire);
        grant_d  = (state == IDLE) && d_req && !(i_req && streak_max);
        grant_i  = (state == IDLE) && i_req && !grant_d;
        state_nx = state;
        if (state == IDLE)
            state_nx = grant_d ? D_BUSY : grant_i ? I_BUSY : IDLE;
        else if (done)
            state_nx = IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // transaction registers: latched on grant, held through BUSY, enables cleared on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
        end else if (done) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // consecutive data grants made while a fetch was waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            streak <= '0;
        else if (grant_d)
            streak <= i_req ? (streak_max ? streak : streak + 1'b1) : '0;
        else if (grant_i)
            streak <= '0;
    end

    // sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (expire && !mem_ack)
            err <= 1'b1;
    end

    assign i_stall = i_req && !((state == I_BUSY) && done);
    assign d_stall = d_req && !((state == D_BUSY) && done);
    assign i_rdata = ((state == I_BUSY) && mem_ack) ? mem_rdata : '0;
    assign d_rdata = ((state == D_BUSY) && mem_ack) ? mem_rdata : '0;

endmodule
